// File: rtl/uart_rx_deframer_if.sv
// Byte-stream handshake between the UART deframer FIFO and its consumer.
interface uart_rx_deframer_if;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;

   modport master (output data_o, output valid_o, input ready_i);
   modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receiver: synchronizes the SoC tx line, deframes bytes and
// buffers them in a small FIFO with valid/ready output and RTS flow control.
module uart_rx_deframer #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_i,
   uart_rx_deframer_if.master        rx_bus,
   output logic                      rts_o,
   output logic                      frame_err_o,
   output logic                      overrun_o
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam logic [15:0] HALF_C  = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] LAST_C  = 16'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] CONE_C  = (AW + 1)'(1);
   localparam logic [AW-1:0] PONE_C = AW'(1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic          rx_m, rx_s;
   logic [2:0]    state;
   logic [15:0]   cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic          stop_smp, push_req, pop, full, push_ok;

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_i;
         rx_s <= rx_m;
      end
   end

   // Frame deframing state machine: mid-start check, 8 data bits, stop check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state <= S_START;
                  cnt   <= '0;
               end
            end
            S_START: begin
               if (cnt == HALF_C) begin
                  if (!rx_s) begin
                     state   <= S_DATA;
                     cnt     <= '0;
                     bit_idx <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (cnt == LAST_C) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) state <= S_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (cnt == LAST_C) begin
                  cnt   <= '0;
                  state <= rx_s ? S_IDLE : S_BREAK;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_BREAK: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Push/pop decode; a full FIFO still accepts a push when a pop frees a slot.
   always_comb begin
      stop_smp  = (state == S_STOP) && (cnt == LAST_C);
      push_req  = stop_smp && rx_s;
      full      = (count == DEPTH_C);
      pop       = (count != '0) && rx_bus.ready_i;
      push_ok   = push_req && (!full || pop);
      count_nxt = count;
      if (push_ok && !pop)      count_nxt = count + CONE_C;
      else if (!push_ok && pop) count_nxt = count - CONE_C;
   end

   // FIFO storage, pointers, occupancy and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rts_o       <= 1'b1;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + PONE_C;
         end
         if (pop) rd_ptr <= rd_ptr + PONE_C;
         count       <= count_nxt;
         rts_o       <= (count_nxt < (DEPTH_C - CONE_C));
         frame_err_o <= stop_smp && !rx_s;
         overrun_o   <= push_req && full && !pop;
      end
   end

   assign rx_bus.valid_o = (count != '0);
   assign rx_bus.data_o  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: stimulus queues expected bytes and
// error events; an independent monitor checks every pop and pulse.
module tb_uart_rx_deframer;
   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_i = 1'b1;
   logic rts_o, frame_err_o, overrun_o;

   uart_rx_deframer_if bus ();

   uart_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_i        (rx_i),
      .rx_bus      (bus.master),
      .rts_o       (rts_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int valid_cycles = 0;
   int model_cnt = 0;
   logic [7:0] exp_data [$];
   int         exp_evt  [$];   // 1 = framing error, 2 = overrun

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares each accepted byte and each error pulse with the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.valid_o) valid_cycles++;
         if (bus.valid_o && bus.ready_i) begin
            if (exp_data.size() == 0) check("pop_unexpected", {24'd0, bus.data_o}, 32'hFFFF_FFFF);
            else                      check("pop_data", {24'd0, bus.data_o}, {24'd0, exp_data.pop_front()});
         end
         if (frame_err_o || overrun_o) begin
            if (exp_evt.size() == 0) check("evt_unexpected", {30'd0, overrun_o, frame_err_o}, 32'd0);
            else                     check("evt_kind", overrun_o ? 32'd2 : 32'd1, exp_evt.pop_front());
         end
      end
   end

   task automatic drive_bit(input logic v);
      @(posedge clk);
      #2 rx_i = v;
      repeat (CPB - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned hold);
      drive_bit(1'b0);
      for (int k = 0; k < 8; k++) drive_bit(b[k]);
      drive_bit(stop);
      if (!stop) begin
         repeat (hold) drive_bit(1'b0);
         drive_bit(1'b1);
         drive_bit(1'b1);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && exp_data.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      check("drain_remaining", exp_data.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, bus.valid_o}, 0);
      check({tag, "_data"},  {24'd0, bus.data_o},  0);
      check({tag, "_rts"},   {31'd0, rts_o},       1);
      check({tag, "_ferr"},  {31'd0, frame_err_o}, 0);
      check({tag, "_ovr"},   {31'd0, overrun_o},   0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      int         v0;
      logic       rdy, ferr;

      bus.ready_i = 1'b0;
      #23 check_idle_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Good frame, consumer ready.
      @(negedge clk) bus.ready_i = 1'b1;
      valid_cycles = 0;
      exp_data.push_back(8'h55);
      send_frame(8'h55, 1'b1, 0);
      repeat (6) @(posedge clk);
      check("good_valid_cycles", valid_cycles, 1);

      // Short low glitch must not start a frame.
      valid_cycles = 0;
      @(posedge clk); #2 rx_i = 1'b0;
      repeat (3) @(posedge clk); #2 rx_i = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("glitch_valid", {31'd0, bus.valid_o}, 0);
      check("glitch_valid_cycles", valid_cycles, 0);

      // Framing error with a long break, then a clean frame.
      exp_evt.push_back(1);
      send_frame(8'hA3, 1'b0, 20);
      check("ferr_no_push", valid_cycles, 0);
      exp_data.push_back(8'h12);
      send_frame(8'h12, 1'b1, 0);
      repeat (6) @(posedge clk);
      check("ferr_then_good", valid_cycles, 1);

      // Flow control and overrun with the consumer stalled.
      @(negedge clk) bus.ready_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= DEPTH) exp_data.push_back(8'(i));
         else            exp_evt.push_back(2);
         send_frame(8'(i), 1'b1, 0);
         repeat (3) @(posedge clk);
         @(negedge clk);
         check($sformatf("flow_rts_%0d", i), {31'd0, rts_o}, (i < 3) ? 1 : 0);
         check($sformatf("flow_valid_%0d", i), {31'd0, bus.valid_o}, 1);
      end
      @(negedge clk) bus.ready_i = 1'b1;
      wait_drain();
      @(negedge clk);
      check("flow_rts_after_drain", {31'd0, rts_o}, 1);

      // Full FIFO with a pop in exactly the push cycle, frames back to back.
      bus.ready_i = 1'b0;
      for (int i = 0; i < 5; i++) exp_data.push_back(8'hA0 + 8'(i));
      for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b1, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("full_rts", {31'd0, rts_o}, 0);
      fork
         send_frame(8'hA4, 1'b1, 0);
         begin
            @(posedge clk);
            repeat (78) @(posedge clk);
            #2 bus.ready_i = 1'b1;
            @(posedge clk);
            #2 bus.ready_i = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("fullpop_queue_left", exp_data.size(), 4);
      check("fullpop_valid", {31'd0, bus.valid_o}, 1);
      check("fullpop_rts", {31'd0, rts_o}, 0);
      bus.ready_i = 1'b1;
      wait_drain();

      // Asynchronous reset in the middle of data bit 4.
      @(negedge clk) bus.ready_i = 1'b0;
      exp_data.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("prereset_valid", {31'd0, bus.valid_o}, 1);
      b = 8'h5A;
      drive_bit(1'b0);
      for (int k = 0; k < 4; k++) drive_bit(b[k]);
      @(posedge clk); #2 rx_i = b[4];
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_idle_outputs("midreset");
      exp_data.delete();
      model_cnt = 0;
      rx_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      bus.ready_i = 1'b1;
      v0 = valid_cycles;
      exp_data.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, 0);
      wait_drain();
      check("postreset_one_byte", valid_cycles - v0, 1);

      // Randomized frames against the occupancy model.
      for (int n = 0; n < 30; n++) begin
         rdy  = ($urandom_range(0, 3) == 0);
         ferr = ($urandom_range(0, 7) == 0);
         b    = 8'($urandom);
         @(negedge clk) bus.ready_i = rdy;
         if (rdy) model_cnt = 0;
         if (ferr) begin
            exp_evt.push_back(1);
            send_frame(b, 1'b0, 2);
         end else begin
            if (model_cnt < DEPTH) begin
               exp_data.push_back(b);
               model_cnt++;
            end else begin
               exp_evt.push_back(2);
            end
            send_frame(b, 1'b1, 0);
         end
         if (rdy) model_cnt = 0;
         repeat (4) @(posedge clk);
         @(negedge clk);
         check("rand_valid", {31'd0, bus.valid_o}, (model_cnt != 0) ? 1 : 0);
         check("rand_rts", {31'd0, rts_o}, (model_cnt < DEPTH - 1) ? 1 : 0);
      end
      @(negedge clk) bus.ready_i = 1'b1;
      wait_drain();
      check("events_outstanding", exp_evt.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Synthesizable UART receiver on the host/transactor side of the SoC serial link. It deframes the SoC `uart_tx` line (8N1, LSB first, idle high) into bytes and buffers them in a small FIFO with a valid/ready output. It drives an RTS-style flow-control flag back toward the SoC. It is the receive counterpart to the SoC UART transmit path and runs on the transactor clock domain.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 8: byte FIFO entries; power of two, ≥ 2.
- `clk`  input  1  transactor clock; single clock domain.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `rx_i`  input  1  serial line from SoC `uart_tx`; asynchronous to `clk`.
- `data_o`  output  8  FIFO head byte.
- `valid_o`  output  1  FIFO non-empty.
- `ready_i`  input  1  consumer accepts `data_o` when `valid_o & ready_i`.
- `rts_o`  output  1  high = room available (FIFO count < FIFO_DEPTH-1).
- `frame_err_o`  output  1  one-cycle pulse on a bad stop bit.
- `overrun_o`  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rx_i` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- 16-bit-safe bit counter `cnt`, 3-bit index `bit_idx`, 8-bit shift register.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s`=0, go to START and set `cnt`=0.
  - START: at `cnt`=CLKS_PER_BIT/2-1 (integer division), check `rx_s`.
    - `rx_s`=0: go to DATA, set `cnt`=0, `bit_idx`=0.
    - `rx_s`=1: glitch; return to IDLE. No output.
  - DATA: at `cnt`=CLKS_PER_BIT-1, shift `rx_s` into bit `bit_idx` (LSB first) and set `cnt`=0. After `bit_idx`=7, go to STOP.
  - STOP: at `cnt`=CLKS_PER_BIT-1, sample `rx_s`.
    - 1: push byte and go to IDLE.
    - 0: pulse `frame_err_o`, discard byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This blocks retriggering while the line is held low.
- FIFO push and pop rules:
  - Push when not full: the byte is written.
  - Push when full with no pop in the same cycle: the byte is dropped and `overrun_o` pulses.
  - Push when full with a pop (`valid_o & ready_i`) in the same cycle: the push is accepted and there is no overrun.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- `data_o` is the registered FIFO head. It is stable while `valid_o` is high and `ready_i` is low.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `rts_o`=1, `frame_err_o`=0, `overrun_o`=0. The FSM is in IDLE and the FIFO is empty.
- Reset mid-frame discards the partial byte and the FIFO contents immediately (asynchronous).
- `rx_i` edge to `rx_s`: 2 cycles.
- With the START entry cycle at t0:
  - mid-start sample at t0 + CLKS_PER_BIT/2 - 1.
  - data bit k sampled CLKS_PER_BIT·(k+1) cycles after the mid-start sample.
  - stop bit sampled 9·CLKS_PER_BIT cycles after the mid-start sample.
- `valid_o` rises the cycle after the stop sample when the FIFO was empty. `frame_err_o` and `overrun_o` pulse in that same cycle.
- `rts_o` is registered from the count and updates the cycle after a push or pop.
- Back-to-back frames: the next start bit may begin immediately after the stop sample. IDLE checks `rx_s` on the following cycle.

## Test plan
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4.

- Good frame: drive 0x55 framed 8N1 with `ready_i`=1 -> `valid_o` high exactly 1 cycle, `data_o`=0x55, no error pulses.
- Glitch: `rx_i` low 3 cycles, then high -> FSM returns to IDLE, `valid_o` stays 0, no pulses.
- Framing error: 0xA3 with stop bit 0, line held low 20 bit-times -> one `frame_err_o` pulse, no push, FSM stays in BREAK. Then line high and 0x12 sent -> `data_o`=0x12 valid.
- Flow control and overrun: `ready_i`=0, send 0x01–0x05.
  - `rts_o` falls after the 3rd byte.
  - The 5th byte gives an `overrun_o` pulse.
  - Then `ready_i`=1 -> bytes pop in order 0x01,0x02,0x03,0x04.
- Full plus pop in the same cycle: FIFO full, `ready_i` asserted exactly in the push cycle -> no overrun, count stays 4, new byte at the tail.
- Reset mid-frame: deassert `rst_n` during data bit 4 -> all outputs at reset values asynchronously. After release, a full 0xC3 frame is received correctly.
